booth_mult: RTL and testbench
=============================

Name: booth_mult

Overview:
- Sequential signed multiplier using Booth recoding: two's-complement WIDTH x WIDTH operands in, 2*WIDTH-bit exact product out.
- Iterative, one Booth step per clock, with a start/done handshake.
- Arithmetic leaf block used by datapaths that can tolerate multi-cycle latency in exchange for a small area.

Parameters:
- WIDTH, 8, operand width in bits; must be even and >= 4; product is 2*WIDTH bits.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  request; sampled on clk; accepted only when not busy.
- multiplicand  input  WIDTH  signed operand M; captured on accept.
- multiplier  input  WIDTH  signed operand Q; captured on accept.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when product becomes valid.
- product  output  2*WIDTH  signed result; held until the next accepted start's completion.

Behaviour:
- Reset:
  - On a rising edge with rst_n=0: state=IDLE, busy=0, done=0, product=0, internal registers cleared.
  - Reset mid-operation aborts the operation; no done pulse is produced.
- States are IDLE, RUN and DONE.
  - IDLE: start=1 at edge t0 accepts the request. Load A=0 (WIDTH+1 bits, sign-extended), Qreg=multiplier, q_m1=0, Mreg=multiplicand sign-extended to WIDTH+1, count=0. Go to RUN, busy=1.
  - RUN: on each edge, examine {Qreg[0], q_m1}:
    - 01: A=A+Mreg.
    - 10: A=A-Mreg.
    - 00 or 11: no add.
    - Then arithmetic right shift of {A, Qreg, q_m1} by 1, replicating A's MSB. count increments.
  - After WIDTH steps (edge t0+WIDTH): product = {A[WIDTH-1:0], Qreg}, done=1, busy=0, go to DONE.
  - DONE: lasts one cycle, then returns to IDLE with done=0. A start seen in DONE is accepted exactly as in IDLE, so back-to-back operations have zero idle gap.
- Latency: product is visible and done=1 in the cycle after edge t0+WIDTH, i.e. WIDTH cycles after acceptance.
- start while busy=1 is ignored; operands are not re-sampled. Operand changes during RUN have no effect.
- Arithmetic:
  - The accumulator is WIDTH+1 bits so that subtracting M = -2^(WIDTH-1) cannot overflow.
  - Results are exact for all operand pairs, including -2^(WIDTH-1) * -2^(WIDTH-1) = +2^(2*WIDTH-2).
- product changes only on completion or reset. done is never asserted together with busy.

Optional Feature:
- Macro BOOTH_MULT_RADIX4_EN.
- When defined: modified Booth radix-4 recoding. Each step examines {Qreg[1:0], q_m1} and adds 0, ±M or ±2M, then arithmetic-shifts by 2.
  - The accumulator is widened to WIDTH+2 bits.
  - Step count is WIDTH/2, so latency is WIDTH/2 cycles.
  - Results and handshake are otherwise identical.
- When undefined: radix-2 as described above, latency WIDTH cycles.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with start=1 -> busy=0, done=0, product=0; no operation starts.
- Basic products, each started from IDLE, checking done exactly WIDTH cycles after accept (WIDTH=8):
  - 127 * -1 -> product=-127 (0xFF81).
  - 0 * 85 -> 0.
  - -128 * 1 -> -128 (0xFF80).
  - 64 * 2 -> 128.
  - 5 * 5 -> 25.
  - 100 * 1 -> 100.
- Extremes: -128 * -128 -> 16384 (0x4000); 127 * 127 -> 16129; -128 * 127 -> -16256. All must be exact with no overflow.
- Handshake: pulse start with 3*4, then pulse start again with 7*7 and change the operands while busy -> that start is ignored, single done, product=12. Then start during the DONE cycle with -6*7 -> accepted immediately, product=-42, WIDTH cycles later.
- Reset mid-operation: start 9*9, assert rst_n=0 at step 4 -> no done pulse, product=0, busy=0. A new start of 9*9 after release -> product=81.
- Random: 1000 random signed operand pairs, compared with a reference multiply -> all match. Repeat with BOOTH_MULT_RADIX4_EN defined, checking latency of WIDTH/2 cycles.

Source files
------------

// File: rtl/booth_mult.sv
// Iterative signed Booth multiplier (WIDTH x WIDTH -> 2*WIDTH), one recoding step per clock.
// Define BOOTH_MULT_RADIX4_EN for radix-4 recoding (WIDTH/2 steps); default is radix-2 (WIDTH steps).
module booth_mult #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

`ifdef BOOTH_MULT_RADIX4_EN
  localparam int ACC_W = WIDTH + 2;
  localparam int STEPS = WIDTH / 2;
`else
  localparam int ACC_W = WIDTH + 1;
  localparam int STEPS = WIDTH;
`endif
  localparam int CNT_W = $clog2(STEPS + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             state_reg, state_next;
  logic [ACC_W-1:0]   a_reg, m_reg;
  logic [WIDTH-1:0]   q_reg;
  logic               q_m1_reg;
  logic [CNT_W-1:0]   count_reg;

  logic               accept, last;
  logic [ACC_W-1:0]   addend, sum, a_step;
  logic [WIDTH-1:0]   q_step;
  logic               q_m1_step;

  assign accept = start && (state_reg != S_RUN);
  assign last   = (count_reg == CNT_W'(STEPS - 1));

  // One Booth step: recode, add into the accumulator, then arithmetic shift {A, Q, q_m1}.
  always_comb begin
    addend = '0;
`ifdef BOOTH_MULT_RADIX4_EN
    case ({q_reg[1:0], q_m1_reg})
      3'b001, 3'b010: addend = m_reg;
      3'b011:         addend = m_reg << 1;
      3'b100:         addend = -(m_reg << 1);
      3'b101, 3'b110: addend = -m_reg;
      default:        addend = '0;
    endcase
    sum       = a_reg + addend;
    a_step    = {{2{sum[ACC_W-1]}}, sum[ACC_W-1:2]};
    q_step    = {sum[1:0], q_reg[WIDTH-1:2]};
    q_m1_step = q_reg[1];
`else
    case ({q_reg[0], q_m1_reg})
      2'b01:   addend = m_reg;
      2'b10:   addend = -m_reg;
      default: addend = '0;
    endcase
    sum       = a_reg + addend;
    a_step    = {sum[ACC_W-1], sum[ACC_W-1:1]};
    q_step    = {sum[0], q_reg[WIDTH-1:1]};
    q_m1_step = q_reg[0];
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (accept) state_next = S_RUN;
      S_RUN:   if (last)   state_next = S_DONE;
      S_DONE:  state_next = accept ? S_RUN : S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_reg == S_RUN);
    done = (state_reg == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_reg     <= '0;
      m_reg     <= '0;
      q_reg     <= '0;
      q_m1_reg  <= 1'b0;
      count_reg <= '0;
      product   <= '0;
    end else if (accept) begin
      a_reg     <= '0;
      m_reg     <= {{(ACC_W-WIDTH){multiplicand[WIDTH-1]}}, multiplicand};
      q_reg     <= multiplier;
      q_m1_reg  <= 1'b0;
      count_reg <= '0;
    end else if (state_reg == S_RUN) begin
      a_reg     <= a_step;
      q_reg     <= q_step;
      q_m1_reg  <= q_m1_step;
      count_reg <= count_reg + CNT_W'(1);
      // Capture from the post-step values so the product is ready with done.
      if (last) product <= {a_step[WIDTH-1:0], q_step};
    end
  end

endmodule

// File: tb/tb_booth_mult.sv
// Bench for booth_mult: vector table, handshake/reset sequences and random pairs, checked via a scoreboard.
module tb_booth_mult;
  localparam int WIDTH = 8;
`ifdef BOOTH_MULT_RADIX4_EN
  localparam int LAT = WIDTH / 2;
`else
  localparam int LAT = WIDTH;
`endif

  logic                clk = 1'b0;
  logic                rst_n;
  logic                start;
  logic [WIDTH-1:0]    multiplicand, multiplier;
  logic                busy, done;
  logic [2*WIDTH-1:0]  product;

  booth_mult #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .multiplicand(multiplicand), .multiplier(multiplier),
    .busy(busy), .done(done), .product(product)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic signed [WIDTH-1:0]   m;
    logic signed [WIDTH-1:0]   q;
    logic signed [2*WIDTH-1:0] p;
  } vec_t;

  typedef struct {
    logic signed [2*WIDTH-1:0] p;
    int                        t0;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[9];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every done pulse must match the oldest pending operation.
  always @(negedge clk) begin
    exp_t e;
    if (done === 1'b1) begin
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL done_busy: got busy=%b want 0 while done=1", busy);
      end
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL spurious_done: got done=1 at cycle %0d want no pulse", cyc);
      end else begin
        e = sb.pop_front();
        $display("op done cycle %0d: product=%0d expected=%0d", cyc, $signed(product), e.p);
        if (product !== e.p) begin
          errors++;
          $display("FAIL product: got %0d want %0d", $signed(product), e.p);
        end
        checks++;
        if (cyc - e.t0 != LAT) begin
          errors++;
          $display("FAIL latency: got %0d want %0d", cyc - e.t0, LAT);
        end
      end
    end
  end

  // Call at a negedge; drives one start and records the accepting edge.
  task automatic do_op(input logic signed [WIDTH-1:0] m, input logic signed [WIDTH-1:0] q,
                       input logic signed [2*WIDTH-1:0] p, output int t0);
    exp_t e;
    start        = 1'b1;
    multiplicand = m;
    multiplier   = q;
    @(posedge clk);
    #1;
    t0   = cyc;
    e.p  = p;
    e.t0 = t0;
    sb.push_back(e);
    start = 1'b0;
  endtask

  task automatic drain();
    int k;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      #2;
      if (sb.size() == 0) break;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending ops want 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic check_idle(input string name);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== '0) begin
      errors++;
      $display("FAIL %s: got busy=%b done=%b product=%0d want 0/0/0", name, busy, done, product);
    end
  endtask

  initial begin
    int t0;
    logic signed [WIDTH-1:0]   ra, rb;
    logic signed [2*WIDTH-1:0] rp;

    tbl[0] = '{m:  127, q:   -1, p:  -127};
    tbl[1] = '{m:    0, q:   85, p:     0};
    tbl[2] = '{m: -128, q:    1, p:  -128};
    tbl[3] = '{m:   64, q:    2, p:   128};
    tbl[4] = '{m:    5, q:    5, p:    25};
    tbl[5] = '{m:  100, q:    1, p:   100};
    tbl[6] = '{m: -128, q: -128, p: 16384};
    tbl[7] = '{m:  127, q:  127, p: 16129};
    tbl[8] = '{m: -128, q:  127, p: -16256};

    // Reset held with start asserted: nothing may start.
    rst_n = 1'b0; start = 1'b1; multiplicand = 8'd5; multiplier = 8'd5;
    repeat (2) @(posedge clk);
    #1;
    check_idle("reset_state");
    @(negedge clk);
    rst_n = 1'b1; start = 1'b0;
    @(posedge clk);
    #1;
    check_idle("post_reset_idle");
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      $display("vec %0d: %0d * %0d", i, tbl[i].m, tbl[i].q);
      do_op(tbl[i].m, tbl[i].q, tbl[i].p, t0);
      drain();
    end

    // Start while busy is ignored; start in the DONE cycle is taken immediately.
    do_op(8'sd3, 8'sd4, 16'sd12, t0);
    @(negedge clk);
    @(negedge clk);
    start = 1'b1; multiplicand = 8'sd7; multiplier = 8'sd7;
    @(posedge clk);
    #1;
    start = 1'b0; multiplicand = -8'sd3; multiplier = 8'sd11;
    for (int k = 0; k < 50 && cyc != t0 + LAT; k++) @(negedge clk);
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL done_cycle_handshake: got done=%b want 1", done);
    end
    do_op(-8'sd6, 8'sd7, -16'sd42, t0);
    drain();

    // Reset in the middle of an operation aborts it without a done pulse.
    do_op(8'sd9, 8'sd9, 16'sd81, t0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    sb.delete();
    check_idle("abort_reset");
    repeat (LAT + 2) @(posedge clk);
    #1;
    check_idle("abort_no_done");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_op(8'sd9, 8'sd9, 16'sd81, t0);
    drain();

    for (int i = 0; i < 1000; i++) begin
      ra = WIDTH'($urandom_range(255));
      rb = WIDTH'($urandom_range(255));
      rp = (2*WIDTH)'(ra) * (2*WIDTH)'(rb);
      do_op(ra, rb, rp, t0);
      drain();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
